// File: rtl/enc_backend.sv
// rtl/enc_backend.sv - captures a multi-lane cipher result word and drains enabled lanes as a block stream
module enc_backend #(
  parameter int LANES      = 32,
  parameter int BLOCK_W    = 128,
  parameter int LANE_IDX_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BLOCK_W-1:0] inBus,
  input  logic [LANES-1:0]         in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BLOCK_W-1:0]       outStream,
  output logic [LANE_IDX_W-1:0]    out_lane,
  output logic                     out_last,
  output logic [CNT_W-1:0]         frames_done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state, state_next;
  logic [LANES*BLOCK_W-1:0] word_q;
  logic [LANES-1:0]         mask_q;
  logic [LANES-1:0]         mask_rem;
  logic [LANES-1:0]         src_mask;
  logic [LANES*BLOCK_W-1:0] src_word;
  logic [LANE_IDX_W-1:0]    lo_idx;
  logic                     lo_last;
  logic                     capture;
  logic                     beat;
  logic                     load;
  logic                     count;

  assign out_valid = (state == DRAIN);
  assign capture   = (state == IDLE) && in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, pick the mask/word the priority encoder looks at, and decide when outputs reload
  always_comb begin
    state_next = state;
    mask_rem   = mask_q;
    mask_rem[out_lane] = 1'b0;
    src_mask   = mask_rem;
    src_word   = word_q;
    load       = 1'b0;
    count      = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          src_mask = in_mask;
          src_word = inBus;
          if (in_mask != '0) begin
            state_next = DRAIN;
            load       = 1'b1;
          end else begin
            count = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_next = IDLE;
            count      = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lowest set lane of the remaining mask, and whether any lane above it is still pending
  always_comb begin
    lo_idx  = '0;
    lo_last = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (src_mask[i]) lo_idx = LANE_IDX_W'(i);
    end
    for (int i = 0; i < LANES; i++) begin
      if (src_mask[i] && (i > int'(lo_idx))) lo_last = 1'b0;
    end
  end

  // Captured word, pending mask, registered stream outputs and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      word_q      <= '0;
      mask_q      <= '0;
      outStream   <= '0;
      out_lane    <= '0;
      out_last    <= 1'b0;
      frames_done <= '0;
    end else begin
      in_ready <= (state_next == IDLE);
      if (capture) begin
        word_q <= inBus;
        mask_q <= in_mask;
      end else if (beat) begin
        mask_q <= mask_rem;
      end
      if (load) begin
        outStream <= src_word[int'(lo_idx)*BLOCK_W +: BLOCK_W];
        out_lane  <= lo_idx;
        out_last  <= lo_last;
      end
      if (count) frames_done <= frames_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_enc_backend.sv
// tb/tb_enc_backend.sv - randomized and directed self-checking bench for enc_backend
module tb_enc_backend;

  localparam int LANES = 32;
  localparam int BW    = 128;
  localparam int LW    = 5;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*BW-1:0]   in_bus;
  logic [LANES-1:0]      in_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW-1:0]         out_stream;
  logic [LW-1:0]         out_lane;
  logic                  out_last;
  logic [CW-1:0]         frames_done;

  enc_backend #(.LANES(LANES), .BLOCK_W(BW), .LANE_IDX_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .inBus(in_bus), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .outStream(out_stream),
    .out_lane(out_lane), .out_last(out_last), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       mq[$];
  logic        m_ready;
  int          m_frames;
  int          vectors = 0;
  int          errors  = 0;
  int          log_lane[$];
  int          log_lo[$];
  logic        log_last[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a capture expands into a list of beats, one per enabled lane
  task automatic model_edge();
    beat_t b;
    int    hi;
    if (mq.size() > 0) begin
      if (out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_frames = (m_frames + 1) % (1 << CW);
          m_ready  = 1'b1;
        end
      end
    end else if (m_ready && in_valid) begin
      if (in_mask == 0) begin
        m_frames = (m_frames + 1) % (1 << CW);
      end else begin
        hi = 0;
        for (int i = 0; i < LANES; i++) if (in_mask[i]) hi = i;
        for (int i = 0; i < LANES; i++) begin
          if (in_mask[i]) begin
            b.lane = i;
            b.data = in_bus[i*BW +: BW];
            b.last = (i == hi);
            mq.push_back(b);
          end
        end
        m_ready = 1'b0;
      end
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("frames_done", frames_done, m_frames);
    if (mq.size() > 0) begin
      chk("out_lane", out_lane, mq[0].lane);
      chk("outStream", out_stream, mq[0].data);
      chk("out_last", out_last, mq[0].last);
    end
  endtask

  task automatic step();
    if (rst_n && out_valid && out_ready) begin
      log_lane.push_back(int'(out_lane));
      log_lo.push_back(int'(out_stream[31:0]));
      log_last.push_back(out_last);
    end
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_log();
    log_lane.delete();
    log_lo.delete();
    log_last.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < LANES; i++)
      in_bus[i*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_bus    = '0;
    out_ready = 1'b0;
    mq.delete();
    m_ready   = 1'b0;
    m_frames  = 0;
    repeat (2) @(negedge clk);
    compare();
    chk("reset_outStream", out_stream, 0);
    chk("reset_out_lane", out_lane, 0);
    chk("reset_out_last", out_last, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", in_ready, 1);

    // Full mask, lane i carries i+1
    for (int i = 0; i < LANES; i++) in_bus[i*BW +: BW] = BW'(i + 1);
    in_mask  = '1;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_log();
    repeat (32) step();
    chk("full_beats", log_lane.size(), 32);
    for (int i = 0; i < log_lane.size(); i++) begin
      chk("full_lane", log_lane[i], i);
      chk("full_data", log_lo[i], i + 1);
      chk("full_last", log_last[i], i == 31);
    end
    chk("full_frames", frames_done, 1);
    chk("full_ready_after", in_ready, 1);

    // Sparse mask: lanes 0 and 31 only
    fill_random();
    in_mask  = 32'h8000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clear_log();
    repeat (2) step();
    chk("sparse_beats", log_lane.size(), 2);
    if (log_lane.size() == 2) begin
      chk("sparse_lane0", log_lane[0], 0);
      chk("sparse_last0", log_last[0], 0);
      chk("sparse_lane1", log_lane[1], 31);
      chk("sparse_last1", log_last[1], 1);
    end
    chk("sparse_done_valid", out_valid, 0);

    // Single lane 2 with a 5-cycle stall
    fill_random();
    in_mask   = 32'h0000_0004;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    clear_log();
    repeat (5) begin
      step();
      chk("stall_lane", out_lane, 2);
      chk("stall_last", out_last, 1);
    end
    chk("stall_no_beat", log_lane.size(), 0);
    out_ready = 1'b1;
    step();
    chk("stall_beats", log_lane.size(), 1);
    chk("stall_frames", frames_done, 3);

    // Empty mask: counts a frame, no beat
    in_mask  = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("empty_valid", out_valid, 0);
    chk("empty_ready", in_ready, 1);
    chk("empty_frames", frames_done, 4);

    // Reset after 3 of 8 beats
    fill_random();
    in_mask  = 32'h00F0_0F00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_frames", frames_done, 0);
    chk("rst_mid_ready", in_ready, 0);
    mq.delete();
    m_ready  = 1'b0;
    m_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fill_random();
    in_mask  = 32'h0000_0300;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_lane", out_lane, 8);
    repeat (3) step();

    // Counter wrap with 4-bit counter: 15 then 0
    in_mask  = '0;
    in_valid = 1'b1;
    while (frames_done != 4'hF && vectors < 100000) step();
    chk("wrap_pre", frames_done, 15);
    step();
    chk("wrap_post", frames_done, 0);
    in_valid = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: in_mask = '0;
        1: in_mask = 32'(1) << $urandom_range(0, 31);
        2: in_mask = $urandom & $urandom;
        default: in_mask = '1;
      endcase
      fill_random();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
